// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for an external combinational Ascon-p datapath: accepts a 320-bit state,
// iterates it through rounds S..11 (UROL rounds per clock) and hands the result back.
module ascon_perm_ctrl #(
    parameter int UROL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  rounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o,
    output logic [3:0]  perm_round_cnt_o,
    output logic [63:0] perm_x0_o,
    output logic [63:0] perm_x1_o,
    output logic [63:0] perm_x2_o,
    output logic [63:0] perm_x3_o,
    output logic [63:0] perm_x4_o,
    input  logic [63:0] perm_x0_i,
    input  logic [63:0] perm_x1_i,
    input  logic [63:0] perm_x2_i,
    input  logic [63:0] perm_x3_i,
    input  logic [63:0] perm_x4_i,
    output logic        busy_o
);

    localparam logic [3:0] STEP      = 4'(UROL);
    localparam logic [3:0] LAST_CNT  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [319:0] in_state;
    logic [319:0] perm_state;
    logic         accept;
    logic [3:0]   cnt_step;

    assign in_state   = {x4_i, x3_i, x2_i, x1_i, x0_i};
    assign perm_state = {perm_x4_i, perm_x3_i, perm_x2_i, perm_x1_i, perm_x0_i};

    // First round index so that the tail of the 12-round constant schedule is used.
    function automatic logic [3:0] start_idx(input logic [1:0] sel);
        case (sel)
            2'd1:    return 4'd4;
            2'd2:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    assign in_ready_o = (fsm_q == ST_IDLE) | ((fsm_q == ST_DONE) & out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign cnt_step   = cnt_q + STEP;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            ST_BUSY: begin
                state_d = perm_state;
                cnt_d   = cnt_step;
                if (cnt_step == LAST_CNT) begin
                    fsm_d = ST_DONE;
                end
            end
            default: begin
                if (accept) begin
                    state_d = in_state;
                    cnt_d   = start_idx(rounds_i);
                    fsm_d   = ST_BUSY;
                end else if ((fsm_q == ST_DONE) && out_ready_i) begin
                    fsm_d = ST_IDLE;
                end
            end
        endcase
        out_valid_d = (fsm_d == ST_DONE);
        busy_d      = (fsm_d == ST_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid_o      = out_valid_q;
    assign busy_o           = busy_q;
    assign perm_round_cnt_o = cnt_q;

    assign x0_o = state_q[63:0];
    assign x1_o = state_q[127:64];
    assign x2_o = state_q[191:128];
    assign x3_o = state_q[255:192];
    assign x4_o = state_q[319:256];

    assign perm_x0_o = state_q[63:0];
    assign perm_x1_o = state_q[127:64];
    assign perm_x2_o = state_q[191:128];
    assign perm_x3_o = state_q[255:192];
    assign perm_x4_o = state_q[319:256];

    // Start indices are multiples of UROL, so the counter lands exactly on 12.
    cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST_CNT);
    urol_legal_a: assert property (@(posedge clk) (UROL == 1) || (UROL == 2));

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Sequencer that time-multiplexes one combinational Ascon-p round datapath (asconp, UROL rounds per cycle) over a full p12/p8/p6 permutation. It latches a 320-bit state through a valid/ready input handshake and feeds the state register and a round index to the external permutation each cycle. It writes the permutation result back into the state register and presents the final state through a valid/ready output handshake. It sits between the mode FSM of the Ascon core and the asconp instance.

Parameters:
UROL, 1, rounds per clock. Legal values are 1 and 2. Must equal the UROL of the attached asconp.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid_i  input  1  request: a new state and round count are present
in_ready_o  output  1  controller accepts a request this cycle
rounds_i  input  2  0=p12, 1=p8, 2=p6, 3=reserved (runs p12)
x0_i..x4_i  input  64 each  initial state words
out_valid_o  output  1  final state available
out_ready_i  input  1  consumer takes the final state
x0_o..x4_o  output  64 each  final state words (state register)
perm_round_cnt_o  output  4  index of the first round applied this cycle, to asconp round_cnt
perm_x0_o..perm_x4_o  output  64 each  state register, to asconp x*_i
perm_x0_i..perm_x4_i  input  64 each  asconp x*_o results
busy_o  output  1  high in BUSY

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Every register updates only on the rising edge of clk.
- Reset values:
  - FSM goes to IDLE.
  - State register and x*_o are 0.
  - perm_round_cnt_o is 0.
  - out_valid_o and busy_o are 0.
  - in_ready_o is 1 in the cycle after reset.
- Round indexing:
  - Start index S is 0 for p12, 4 for p8, 6 for p6; reserved uses 0.
  - Rounds S..11 are applied, so constants match the standard Ascon schedule.
  - asconp applies rounds perm_round_cnt_o .. perm_round_cnt_o+UROL-1 combinationally.
- States:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o: state <= x*_i, cnt <= S, go to BUSY.
  - BUSY: state <= perm_x*_i and cnt <= cnt+UROL each cycle. When cnt+UROL==12, go to DONE instead of staying in BUSY. in_ready_o=0. in_valid_i is ignored.
  - DONE: out_valid_o=1 and x*_o hold the final state, stable until accepted.
    - out_ready_i=0: stay in DONE.
    - out_ready_i=1 and in_valid_i=0: go to IDLE.
    - out_ready_i=1 and in_valid_i=1: back-to-back accept. Load the new state, go to BUSY.
- in_ready_o = IDLE | (DONE & out_ready_i). This is the only combinational input-to-output path.
- Latency from accept to out_valid_o is (12-S)/UROL + 1 cycles:
  - UROL=1: p12=13, p8=9, p6=7.
  - UROL=2: p12=7, p8=5, p6=4.
- perm_round_cnt_o = cnt in all states. In IDLE and DONE the value is don't-care for the datapath but must not change while out_valid_o=1.
- rounds_i is sampled only at accept. Changes during BUSY have no effect.
- rst asserted mid-BUSY or mid-DONE: the operation is dropped, all reset values apply next cycle, and no out_valid_o pulse occurs.
- cnt never exceeds 12. Wrap-around beyond 12 is unreachable by construction and must be assertion-checked.

Test Plan:
1. rst held 3 cycles, then released -> out_valid_o=0, busy_o=0, in_ready_o=1, x0_o..x4_o=0, perm_round_cnt_o=0.
2. UROL=1, p12, state all-zero: accept at cycle T.
   - perm_round_cnt_o steps 0,1,...,11 over cycles T+1..T+12.
   - out_valid_o rises at T+13.
   - x*_o equals the golden software Ascon-p12(0).
3. UROL=2, p8 and p6 with state x0=0x80400c0600000000, others 0.
   - p8: perm_round_cnt_o sequence 4,6,8,10, latency 5.
   - p6: perm_round_cnt_o sequence 6,8,10, latency 4.
   - Both results match the golden model.
4. Backpressure then back-to-back: hold out_ready_i=0 for 5 cycles in DONE, then assert out_ready_i with in_valid_i=1.
   - x*_o stable and out_valid_o held during the 5 cycles.
   - in_ready_o=1 in the accept cycle, next request enters BUSY with no IDLE bubble.
5. Assert rst at the 4th BUSY cycle of a p12 -> next cycle IDLE, state 0, and out_valid_o never rises. A subsequent p6 request completes correctly.
6. rounds_i=3 -> behaves exactly as p12. Toggling rounds_i during BUSY leaves latency and result unchanged.
